regfile_write_arbiter: RTL and testbench

//  Shares the single write port of the 32x64 register_file between N_REQ writeback

---
 rtl/rf_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 45 ++++
 rtl/regfile_write_arbiter.sv | 90 +++++++++
 tb/tb_regfile_write_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file geometry and index-width helper.
// Rev 1.0
`default_nettype none

package rf_pkg;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 64;
  localparam int RF_ZERO_REG = 31;
  localparam int RF_NUM_REGS = 32;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting the scan at ptr.
// Rev 1.0
`default_nettype none

module rr_arbiter
  import rf_pkg::*;
#(
  parameter int N     = 2,
  localparam int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_idx;

  // Scan farthest-first so the request nearest to ptr overwrites the rest.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (w_sum >= (IDX_W + 1)'(N)) begin
        w_sum = w_sum - (IDX_W + 1)'(N);
      end
      w_idx = w_sum[IDX_W-1:0];
      if (req[w_idx]) begin
        gnt        = '0;
        gnt[w_idx] = 1'b1;
        gnt_idx    = w_idx;
        any        = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the register-file write port.
// Rev 1.0
`default_nettype none

module regfile_write_arbiter
  import rf_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = RF_ZERO_REG,
  parameter int CNT_W    = 16,
  localparam int GID_W   = idx_width(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic                    regWrite,
  output logic [ADDR_W-1:0]       writeReg,
  output logic [DATA_W-1:0]       writeData,
  output logic [GID_W-1:0]        grant_id,
  output logic [CNT_W-1:0]        conflict_cnt
);

  logic [GID_W-1:0]  r_rr_ptr;
  logic              r_reg_write;
  logic [ADDR_W-1:0] r_write_reg;
  logic [DATA_W-1:0] r_write_data;
  logic [GID_W-1:0]  r_grant_id;
  logic [CNT_W-1:0]  r_conflict_cnt;

  logic [N_REQ-1:0]  w_gnt;
  logic [GID_W-1:0]  w_gnt_idx;
  logic              w_any;
  logic              w_accept;
  logic              w_multi;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  assign req_ready = rst ? '0 : w_gnt;
  assign w_accept  = w_any & ~rst;
  // Clearing the lowest set bit leaves something only if two or more are set.
  assign w_multi   = |(req_valid & (req_valid - N_REQ'(1)));
  assign w_addr    = req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
  assign w_data    = req_data[w_gnt_idx*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr       <= '0;
      r_reg_write    <= 1'b0;
      r_write_reg    <= '0;
      r_write_data   <= '0;
      r_grant_id     <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_write_reg  <= w_addr;
        r_write_data <= w_data;
        r_grant_id   <= w_gnt_idx;
        r_reg_write  <= (w_addr != ADDR_W'(ZERO_REG));
        r_rr_ptr     <= (w_gnt_idx == GID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + GID_W'(1);
      end else begin
        r_reg_write  <= 1'b0;
      end
      if (w_multi && (r_conflict_cnt != '1)) begin
        r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
      end
    end
  end

  assign regWrite     = r_reg_write;
  assign writeReg     = r_write_reg;
  assign writeData    = r_write_data;
  assign grant_id     = r_grant_id;
  assign conflict_cnt = r_conflict_cnt;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks with a register-file model on the write port.
// Rev 1.0
`default_nettype none

module tb_regfile_write_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [9:0]   req_addr;
  logic [127:0] req_data;

  logic [1:0]   req_ready, s_req_ready;
  logic         regWrite, s_regWrite;
  logic [4:0]   writeReg, s_writeReg;
  logic [63:0]  writeData, s_writeData;
  logic         grant_id, s_grant_id;
  logic [15:0]  conflict_cnt;
  logic [3:0]   s_conflict_cnt;

  logic [63:0]  rf [32];
  int           n_chk  = 0;
  int           n_pass = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.N_REQ(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .regWrite(regWrite),
    .writeReg(writeReg), .writeData(writeData), .grant_id(grant_id),
    .conflict_cnt(conflict_cnt)
  );

  regfile_write_arbiter #(.N_REQ(2), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_addr(req_addr), .req_data(req_data), .regWrite(s_regWrite),
    .writeReg(s_writeReg), .writeData(s_writeData), .grant_id(s_grant_id),
    .conflict_cnt(s_conflict_cnt)
  );

  // Register-file model: commits on the edge after regWrite rises, X31 reads zero.
  always @(posedge clk) begin
    if (!rst && regWrite && writeReg != 5'd31) rf[writeReg] <= writeData;
  end

  function automatic logic [63:0] rd(input logic [4:0] a);
    return (a == 5'd31) ? 64'd0 : rf[a];
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [63:0] d0,
                       input logic [4:0] a1, input logic [63:0] d1);
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
    #1;
  endtask

  localparam logic [63:0] D2  = 64'h3762_35E0_1BB1_1AF2;
  localparam logic [63:0] A0  = 64'h0000_0000_AAAA_0000;
  localparam logic [63:0] A1  = 64'h0000_0000_BBBB_1111;
  localparam logic [63:0] V1  = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] V2  = 64'hDEAD_BEEF_0000_0005;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 64'd0;

    // Reset with both requesters valid
    rst = 1'b1;
    drive(2'b11, 5'd13, A0, 5'd14, A1);
    chk("rst_ready", 64'(req_ready), 64'd0);
    tick();
    tick();
    chk("rst_regwrite", 64'(regWrite), 64'd0);
    chk("rst_cnt", 64'(conflict_cnt), 64'd0);
    chk("rst_wreg", 64'(writeReg), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);

    // Single request from requester 0
    rst = 1'b0;
    drive(2'b01, 5'd13, D2, 5'd0, 64'd0);
    chk("single_ready", 64'(req_ready), 64'b01);
    tick();
    chk("single_regwrite", 64'(regWrite), 64'd1);
    chk("single_wreg", 64'(writeReg), 64'd13);
    chk("single_wdata", writeData, D2);
    drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0);
    tick();
    chk("single_read", rd(5'd13), D2);
    chk("single_idle_regwrite", 64'(regWrite), 64'd0);

    // Contention: rr_ptr is 1 after the single grant, so grants go 1,0,1,0
    drive(2'b11, 5'd13, A0, 5'd14, A1);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("cont_ready%0d", c), 64'(req_ready), (c % 2 == 0) ? 64'b10 : 64'b01);
      tick();
      chk($sformatf("cont_gid%0d", c), 64'(grant_id), (c % 2 == 0) ? 64'd1 : 64'd0);
      chk($sformatf("cont_regwrite%0d", c), 64'(regWrite), 64'd1);
    end
    chk("cont_cnt", 64'(conflict_cnt), 64'd4);
    drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0);
    tick();
    chk("cont_read13", rd(5'd13), A0);
    chk("cont_read14", rd(5'd14), A1);
    chk("cont_cnt_hold", 64'(conflict_cnt), 64'd4);

    // Zero-register write is accepted but never asserts regWrite
    drive(2'b10, 5'd0, 64'd0, 5'd31, 64'hFFFF);
    chk("zero_ready", 64'(req_ready), 64'b10);
    tick();
    chk("zero_regwrite", 64'(regWrite), 64'd0);
    chk("zero_gid", 64'(grant_id), 64'd1);
    drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0);
    tick();
    chk("zero_read", rd(5'd31), 64'd0);

    // Mid-operation reset discards the held write and clears rr_ptr
    drive(2'b01, 5'd5, V1, 5'd0, 64'd0);
    tick();
    drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0);
    tick();
    chk("midrst_pre", rd(5'd5), V1);
    drive(2'b01, 5'd5, V2, 5'd0, 64'd0);
    tick();
    chk("midrst_accept", 64'(regWrite), 64'd1);
    rst = 1'b1;
    drive(2'b11, 5'd6, A0, 5'd7, A1);
    chk("midrst_ready", 64'(req_ready), 64'd0);
    tick();
    chk("midrst_regwrite", 64'(regWrite), 64'd0);
    chk("midrst_read5", rd(5'd5), V1);
    rst = 1'b0;
    #1;
    chk("midrst_ptr", 64'(req_ready), 64'b01);
    chk("midrst_cnt", 64'(conflict_cnt), 64'd0);

    // Saturation of the 4-bit counter
    rst = 1'b1;
    drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0);
    tick();
    rst = 1'b0;
    drive(2'b11, 5'd1, A0, 5'd2, A1);
    for (int c = 0; c < 20; c++) tick();
    chk("sat_cnt4", 64'(s_conflict_cnt), 64'd15);
    chk("sat_cnt16", 64'(conflict_cnt), 64'd20);
    for (int c = 0; c < 3; c++) tick();
    chk("sat_hold4", 64'(s_conflict_cnt), 64'd15);
    chk("sat_cnt16b", 64'(conflict_cnt), 64'd23);
    drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

`default_nettype wire
